// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, defaults,
// constant bus words and the latched bus command record.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_D_WAIT = 2'd1;
    localparam logic [1:0] ARB_I_WAIT = 2'd2;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd255;
    localparam int unsigned CNT_W_DEFAULT   = 32'd8;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [3:0]  BE_WORD  = 4'hF;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    function automatic logic is_wait_state(input logic [1:0] st);
        return (st == ARB_D_WAIT) || (st == ARB_I_WAIT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Wait-cycle counter for an outstanding bus transaction; expired_o flags
// that the count has reached TIMEOUT.
module mem_port_arbiter_bus_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT));

    // Wait counter: clear wins over count, and it holds once expired.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM
// stage, with fixed data priority and a watchdog-bounded req/ack handshake.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_abort_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stall_o,
    output logic        mem_bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    logic [1:0]  state_q, state_d;
    bus_cmd_t    cmd_q, cmd_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        d_done_q, d_done_d;
    logic        i_done_q, i_done_d;
    logic        err_q, err_d;
    logic        discard_q, discard_d;
    logic        discard_now_s;
    logic        wd_clr_s, wd_en_s, expired_s;

    mem_port_arbiter_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_bus_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (wd_clr_s),
        .en_i      (wd_en_s),
        .expired_o (expired_s)
    );

    // An abort raised in the completing cycle still suppresses the result.
    assign discard_now_s = discard_q | ((state_q == ARB_I_WAIT) & if_abort_i);

    // Arbitration, handshake sequencing and completion bookkeeping.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bus_req_d   = bus_req_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        d_done_d    = 1'b0;
        i_done_d    = 1'b0;
        err_d       = 1'b0;
        discard_d   = discard_q;
        wd_clr_s    = 1'b0;
        wd_en_s     = is_wait_state(state_q);
        case (state_q)
            ARB_IDLE: begin
                wd_clr_s  = 1'b1;
                discard_d = 1'b0;
                if (mem_req_i && !d_done_q) begin
                    state_d   = ARB_D_WAIT;
                    bus_req_d = 1'b1;
                    cmd_d     = '{we: mem_we_i, be: mem_be_i, addr: mem_addr_i, wdata: mem_wdata_i};
                end else if (if_req_i && !i_done_q && !if_abort_i) begin
                    state_d   = ARB_I_WAIT;
                    bus_req_d = 1'b1;
                    cmd_d     = '{we: 1'b0, be: BE_WORD, addr: if_addr_i, wdata: cmd_q.wdata};
                end else begin
                    bus_req_d = 1'b0;
                end
            end
            ARB_D_WAIT: begin
                if (bus_ack_i || expired_s) begin
                    mem_rdata_d = bus_ack_i ? bus_rdata_i : NOP_WORD;
                    err_d       = ~bus_ack_i;
                    d_done_d    = 1'b1;
                    bus_req_d   = 1'b0;
                    wd_clr_s    = 1'b1;
                    state_d     = ARB_IDLE;
                end else begin
                    state_d = ARB_D_WAIT;
                end
            end
            ARB_I_WAIT: begin
                if (bus_ack_i || expired_s) begin
                    if (!discard_now_s) begin
                        if_rdata_d = bus_ack_i ? bus_rdata_i : NOP_WORD;
                        i_done_d   = 1'b1;
                    end else begin
                        i_done_d = 1'b0;
                    end
                    discard_d = 1'b0;
                    bus_req_d = 1'b0;
                    wd_clr_s  = 1'b1;
                    state_d   = ARB_IDLE;
                end else begin
                    discard_d = discard_now_s;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
                discard_d = 1'b0;
                wd_clr_s  = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ARB_IDLE;
            cmd_q       <= '0;
            bus_req_q   <= 1'b0;
            if_rdata_q  <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
            err_q       <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bus_req_q   <= bus_req_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            d_done_q    <= d_done_d;
            i_done_q    <= i_done_d;
            err_q       <= err_d;
            discard_q   <= discard_d;
        end
    end

    assign mem_stall_o   = mem_req_i & ~d_done_q;
    assign if_stall_o    = if_req_i & ~i_done_q;
    assign if_rdata_o    = if_rdata_q;
    assign mem_rdata_o   = mem_rdata_q;
    assign mem_bus_err_o = err_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = cmd_q.we;
    assign bus_be_o      = cmd_q.be;
    assign bus_addr_o    = cmd_q.addr;
    assign bus_wdata_o   = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level model of the pipeline and a variable-latency memory.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i, if_abort_i, mem_req_i, mem_we_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
    logic [3:0]  mem_be_i;
    logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
    logic        if_stall_o, mem_stall_o, mem_bus_err_o, bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;

    int vectors     = 0;
    int miscompares = 0;

    // Memory model configuration: ack on the lat_cfg-th bus_req cycle, 0 = never.
    int          lat_cfg   = 0;
    logic [31:0] rd_cfg    = 32'h0;
    int          wcnt      = 0;
    bit          force_ack = 1'b0;

    typedef struct {
        bit          is_mem;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } txn_t;

    txn_t q[$];

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_abort_i(if_abort_i),
        .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_stall_o(mem_stall_o), .mem_bus_err_o(mem_bus_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory reacts at the falling edge, outputs settle 1 time unit later.
    task automatic cyc();
        @(negedge clk_i);
        if (bus_req_o) begin
            wcnt++;
            bus_ack_i = (wcnt == lat_cfg);
        end else begin
            wcnt      = 0;
            bus_ack_i = 1'b0;
        end
        if (force_ack) bus_ack_i = 1'b1;
        bus_rdata_i = rd_cfg;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(bus_req_o), 32'd0);
        chk({tag, "_we"},    32'(bus_we_o), 32'd0);
        chk({tag, "_be"},    32'(bus_be_o), 32'd0);
        chk({tag, "_addr"},  bus_addr_o, 32'd0);
        chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_ird"},   if_rdata_o, 32'd0);
        chk({tag, "_mrd"},   mem_rdata_o, 32'd0);
        chk({tag, "_err"},   32'(mem_bus_err_o), 32'd0);
    endtask

    initial begin
        int  n;
        bit  done;
        int  last_w;
        txn_t t;

        reset_i = 1'b1; if_req_i = 1'b0; if_abort_i = 1'b0; mem_req_i = 1'b0;
        mem_we_i = 1'b0; mem_be_i = 4'h0; if_addr_i = 32'h0; mem_addr_i = 32'h0;
        mem_wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        cyc(); cyc();
        chk_all_zero("reset");
        reset_i = 1'b0;
        cyc();

        // 1: zero-wait load
        lat_cfg = 1; rd_cfg = 32'hDEAD_BEEF;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_addr_i = 32'h100;
        #1 chk("t1_stall0", 32'(mem_stall_o), 32'd1);
        cyc();
        chk("t1_req", 32'(bus_req_o), 32'd1);
        chk("t1_addr", bus_addr_o, 32'h100);
        chk("t1_stall1", 32'(mem_stall_o), 32'd1);
        cyc();
        chk("t1_req_low", 32'(bus_req_o), 32'd0);
        chk("t1_stall2", 32'(mem_stall_o), 32'd0);
        chk("t1_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        cyc();
        chk("t1_no_regrant", 32'(bus_req_o), 32'd0);
        mem_req_i = 1'b0;
        cyc();

        // 2: simultaneous store and fetch, data first
        rd_cfg = 32'h5555_0000;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'b0011; mem_addr_i = 32'h200;
        mem_wdata_i = 32'hCAFE_F00D; if_req_i = 1'b1; if_addr_i = 32'h40;
        cyc();
        chk("t2_addr_d", bus_addr_o, 32'h200);
        chk("t2_we_d", 32'(bus_we_o), 32'd1);
        chk("t2_be_d", 32'(bus_be_o), 32'h3);
        chk("t2_wdata", bus_wdata_o, 32'hCAFE_F00D);
        chk("t2_istall_a", 32'(if_stall_o), 32'd1);
        cyc();
        chk("t2_gap", 32'(bus_req_o), 32'd0);
        chk("t2_mstall", 32'(mem_stall_o), 32'd0);
        chk("t2_istall_b", 32'(if_stall_o), 32'd1);
        mem_req_i = 1'b0; rd_cfg = 32'h0000_0013;
        cyc();
        chk("t2_addr_i", bus_addr_o, 32'h40);
        chk("t2_we_i", 32'(bus_we_o), 32'd0);
        chk("t2_be_i", 32'(bus_be_o), 32'hF);
        chk("t2_istall_c", 32'(if_stall_o), 32'd1);
        cyc();
        chk("t2_istall_d", 32'(if_stall_o), 32'd0);
        chk("t2_irdata", if_rdata_o, 32'h0000_0013);
        if_req_i = 1'b0;
        cyc();

        // 3: fetch with 5-cycle ack, aborted at wait cycle 2
        lat_cfg = 5; rd_cfg = 32'h7777_7777;
        if_req_i = 1'b1; if_addr_i = 32'h80;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("t3_req_held", 32'(bus_req_o), 32'd1);
            if_abort_i = (i == 2);
        end
        cyc();
        chk("t3_req_low", 32'(bus_req_o), 32'd0);
        chk("t3_no_done", 32'(if_stall_o), 32'd1);
        chk("t3_rdata_kept", if_rdata_o, 32'h0000_0013);
        if_req_i = 1'b0;
        cyc();

        // 4: data load with no ack times out
        lat_cfg = 0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300;
        n = 0;
        cyc();
        while (bus_req_o && n < 20) begin n++; cyc(); end
        chk("t4_req_cycles", 32'(n), 32'd9);
        chk("t4_err", 32'(mem_bus_err_o), 32'd1);
        chk("t4_rdata", mem_rdata_o, 32'd0);
        chk("t4_stall", 32'(mem_stall_o), 32'd0);
        mem_req_i = 1'b0;
        cyc();
        chk("t4_err_pulse", 32'(mem_bus_err_o), 32'd0);

        // 5: reset during D_WAIT, late ack ignored
        mem_req_i = 1'b1; mem_addr_i = 32'h400; mem_wdata_i = 32'h1111_2222; mem_we_i = 1'b1;
        cyc();
        chk("t5_req", 32'(bus_req_o), 32'd1);
        reset_i = 1'b1; mem_req_i = 1'b0;
        cyc();
        chk_all_zero("t5_rst");
        reset_i = 1'b0; force_ack = 1'b1; rd_cfg = 32'hBAD0_BAD0;
        cyc();
        force_ack = 1'b0;
        cyc();
        chk_all_zero("t5_late");

        // 6: ack coincides with watchdog expiry
        lat_cfg = TO + 1; rd_cfg = 32'h1234_5678;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500;
        n = 0;
        cyc();
        while (bus_req_o && n < 20) begin n++; cyc(); end
        chk("t6_req_cycles", 32'(n), 32'd9);
        chk("t6_rdata", mem_rdata_o, 32'h1234_5678);
        chk("t6_err", 32'(mem_bus_err_o), 32'd0);
        mem_req_i = 1'b0;
        cyc();

        // Randomized scenarios against the transaction-level model
        for (int s = 0; s < 40; s++) begin
            bit dm, di;
            dm = $urandom_range(0, 1) != 0;
            di = $urandom_range(0, 1) != 0;
            if (!dm && !di) dm = 1'b1;
            if (dm) begin
                t.is_mem = 1'b1; t.we = $urandom_range(0, 1) != 0; t.be = 4'($urandom);
                t.addr = $urandom; t.wdata = $urandom;
                t.lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
                t.rdata = $urandom;
                q.push_back(t);
                mem_req_i = 1'b1; mem_we_i = t.we; mem_be_i = t.be;
                mem_addr_i = t.addr; mem_wdata_i = t.wdata;
            end
            if (di) begin
                t.is_mem = 1'b0; t.we = 1'b0; t.be = 4'hF; t.addr = $urandom; t.wdata = 32'h0;
                t.lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
                t.rdata = $urandom;
                q.push_back(t);
                if_req_i = 1'b1; if_addr_i = t.addr;
            end
            n = 0; last_w = 0;
            while (q.size() > 0 && n < 200) begin
                lat_cfg = q[0].lat; rd_cfg = q[0].rdata;
                cyc();
                n++;
                if (bus_req_o) begin
                    last_w = wcnt;
                    if (wcnt == 1) begin
                        chk("r_addr", bus_addr_o, q[0].addr);
                        chk("r_we", 32'(bus_we_o), 32'(q[0].we));
                        chk("r_be", 32'(bus_be_o), 32'(q[0].be));
                        if (q[0].is_mem && q[0].we) chk("r_wdata", bus_wdata_o, q[0].wdata);
                    end
                end
                done = q[0].is_mem ? !mem_stall_o : !if_stall_o;
                if (done) begin
                    chk("r_bus_cycles", 32'(last_w), 32'(q[0].lat == 0 ? TO + 1 : q[0].lat));
                    if (q[0].is_mem) begin
                        chk("r_mrdata", mem_rdata_o, q[0].lat == 0 ? 32'h0 : q[0].rdata);
                        chk("r_err", 32'(mem_bus_err_o), 32'(q[0].lat == 0));
                        mem_req_i = 1'b0;
                    end else begin
                        chk("r_irdata", if_rdata_o, q[0].lat == 0 ? 32'h0 : q[0].rdata);
                        if_req_i = 1'b0;
                    end
                    void'(q.pop_front());
                end
            end
            if (q.size() > 0) begin
                chk("r_timeout_bound", 32'(q.size()), 32'd0);
                q.delete();
                mem_req_i = 1'b0; if_req_i = 1'b0;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and the data access of the MEM stage.
- Sequences each transaction with a req/ack handshake to variable-latency memory, returns read data to the owning stage, and produces the `mem_stall` consumed by the pipeline control unit.
- Guards the bus with a timeout so a missing ack cannot hang the pipeline.
- Sits between the IF/MEM stages and the memory/bus interface.

Parameters:
- TIMEOUT, 255: max wait cycles (bus_req high, no ack) before the transaction is force-completed with error.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF stage wants an instruction word.
- if_addr  in  32  fetch address.
- if_abort  in  1  fetch being flushed (driven from the IF/ID flush); discard the pending fetch result.
- if_rdata  out  32  fetched instruction; valid while if_stall=0 and if_req=1.
- if_stall  out  1  fetch not yet complete.
- mem_req  in  1  MEM stage load/store request.
- mem_we  in  1  1=store, 0=load.
- mem_be  in  4  byte enables.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_stall=0 and mem_req=1.
- mem_stall  out  1  data access not yet complete; feeds the control unit.
- mem_bus_err  out  1  one-cycle pulse with data completion when that access timed out.
- bus_req  out  1  transaction active.
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  memory completes the current transaction this cycle.
- bus_rdata  in  32  read data, sampled when bus_ack=1.

Behaviour:
- FSM states: IDLE, D_WAIT, I_WAIT.
- Registered flags: d_done, i_done (one-cycle pulses), discard, err; wait counter cnt.
- Reset (synchronous) outputs and state:
  - state=IDLE; bus_req/bus_we=0; bus_be/bus_addr/bus_wdata=0.
  - if_rdata=mem_rdata=0; d_done=i_done=0; mem_bus_err=0; discard=0; cnt=0.
  - Reset mid-transaction abandons it immediately, with no ack wait. A late bus_ack arriving in IDLE is ignored.
- Combinational stalls:
  - mem_stall = mem_req & ~d_done.
  - if_stall = if_req & ~i_done.
- IDLE arbitration:
  - If mem_req & ~d_done: latch mem_we/be/addr/wdata onto the bus registers, go to D_WAIT.
  - Else if if_req & ~i_done & ~if_abort: latch if_addr, bus_we=0, bus_be=4'hF, go to I_WAIT.
  - Data has fixed priority over fetch, since the older instruction wins. Fetch starvation is impossible because mem_stall freezes the pipeline until data completes.
  - The done-flag gating prevents re-granting a request that is being consumed in the same cycle.
- D_WAIT / I_WAIT:
  - bus_req=1 and bus fields held constant from the latched values; cnt increments each cycle.
  - On bus_ack:
    - Capture bus_rdata into mem_rdata (D) or if_rdata (I).
    - Pulse d_done, or pulse i_done unless discard=1.
    - bus_req=0 next cycle; cnt=0; go to IDLE.
  - On cnt==TIMEOUT without ack:
    - Data timeout: mem_rdata=0, pulse d_done and mem_bus_err.
    - Fetch timeout: if_rdata=32'h0 (NOP), pulse i_done unless discarded.
    - Go to IDLE.
  - bus_ack and timeout in the same cycle: ack wins, no error.
- if_abort:
  - Asserted in I_WAIT: set discard. The bus transaction still runs to ack/timeout (no abort on the bus); i_done is suppressed and if_rdata is not updated. Discard clears on return to IDLE.
  - Asserted in IDLE: blocks the fetch grant that cycle.
- Latency:
  - Request sampled in IDLE at cycle t, so bus_req is high from t+1.
  - Ack at cycle t+k (k≥1) gives done/rdata at t+k+1.
  - With a zero-wait memory (ack in the first bus_req cycle), completion is 2 cycles after the request.
- Back-to-back: one IDLE cycle separates transactions, so bus_req is low for ≥1 cycle between grants.
- Writes: bus_rdata is captured but ignored by the MEM stage; d_done timing is identical to loads.

Decomposition:
- Shared package holds:
  - FSM state encoding (ARB_IDLE, ARB_D_WAIT, ARB_I_WAIT).
  - Default TIMEOUT.
  - NOP_WORD = 32'h0.
  - BE_WORD = 4'hF.
- Sub-module bus_watchdog holds the clear/enable counter and asserts `expired` when the count reaches TIMEOUT. The arbiter clears it on every return to IDLE.

Test Plan:
1. Zero-wait load: mem_req=1, mem_addr=0x100, ack on first bus_req cycle with bus_rdata=0xDEADBEEF -> bus_req for 1 cycle, mem_stall high 2 cycles, mem_rdata=0xDEADBEEF in the 3rd cycle.
2. Simultaneous if_req (0x40) and mem_req store (0x200, be=4'b0011) -> bus_addr=0x200/bus_we=1 first; fetch of 0x40 issued after one IDLE cycle; if_stall held throughout.
3. Fetch with 5-cycle ack delay and if_abort pulsed at wait cycle 2 -> bus_req held until ack; i_done never pulses; if_rdata unchanged.
4. Data load with no ack, TIMEOUT=8 -> bus_req high 9 cycles; then mem_bus_err=1 and mem_rdata=0 for one cycle; FSM back in IDLE.
5. Reset asserted in D_WAIT, then bus_ack arriving a cycle later -> bus_req=0 the cycle after reset; the ack is ignored; all outputs zero.
6. Ack and watchdog expiry in the same cycle with bus_rdata=0x12345678 -> mem_rdata=0x12345678; mem_bus_err stays 0.
